mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one sequential 8x8 multiplier between two requesters. It accepts an operand pair from the winning requester and issues a single-cycle start to the multiplier. It holds the operands stable until the multiplier signals done, then returns the 16-bit product tagged with the requester ID through a valid/ready response port. It sits between the client blocks and the multiplier datapath plus its control FSM.

---
 rtl/mult_arbiter_if.sv | 49 ++++
 rtl/mult_arbiter.sv | 156 +++++++++++++++
 tb/tb_mult_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - request, response and multiplier-side signal bundle for mult_arbiter
//
// Groups every handshake and datapath signal around the arbiter.
//   master modport : the arbiter itself
//   slave modport  : the surroundings (requesters, response consumer, multiplier)
// Signals:
//   req0_valid/req1_valid, req0_a/b, req1_a/b : operand pairs offered by the requesters
//   req0_ready/req1_ready                      : one-cycle accept pulses
//   rsp_valid/rsp_ready, rsp_id, rsp_product, rsp_err : tagged result
//   mult_start, mult_dataa, mult_datab         : job launch and held operands
//   mult_done, mult_product                    : multiplier completion and result
interface mult_arbiter_if;
   logic        req0_valid;
   logic        req1_valid;
   logic [7:0]  req0_a;
   logic [7:0]  req0_b;
   logic [7:0]  req1_a;
   logic [7:0]  req1_b;
   logic        req0_ready;
   logic        req1_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [15:0] rsp_product;
   logic        rsp_err;
   logic        mult_start;
   logic [7:0]  mult_dataa;
   logic [7:0]  mult_datab;
   logic        mult_done;
   logic [15:0] mult_product;

   modport master (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_product, rsp_err,
      input  rsp_ready,
      output mult_start, mult_dataa, mult_datab,
      input  mult_done, mult_product
   );

   modport slave (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_product, rsp_err,
      output rsp_ready,
      input  mult_start, mult_dataa, mult_datab,
      output mult_done, mult_product
   );
endinterface

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin sharing of one sequential 8x8 multiplier between two requesters
//
// Accepts an operand pair from the winning requester, pulses mult_start once,
// holds the operands until mult_done, then offers the 16-bit product tagged
// with the requester id on a valid/ready response port.
// Ports:
//   i_clk     : rising-edge clock
//   i_reset_a : asynchronous reset, active-high
//   io_arb    : mult_arbiter_if.master (requests, response, multiplier control)
// Parameter:
//   TIMEOUT   : BUSY cycles without mult_done before the job is aborted (1..15)
// Optional feature macro: MULT_ARB_TIMEOUT_EN enables the BUSY watchdog;
// without it BUSY waits indefinitely and rsp_err is tied to 0.
module mult_arbiter #(
   parameter int TIMEOUT = 12
) (
   input  logic           i_clk,
   input  logic           i_reset_a,
   mult_arbiter_if.master io_arb
);

   if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
      $error("mult_arbiter: TIMEOUT must be in 1..15");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BUSY  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t      r_state;
   logic        r_last_grant;
   logic        r_rsp_valid;
   logic        r_rsp_id;
   logic [15:0] r_rsp_product;
   logic        r_mult_start;
   logic [7:0]  r_dataa;
   logic [7:0]  r_datab;

   logic        w_any_valid;
   logic        w_grant_id;
   logic        w_accept;
   logic [7:0]  w_win_a;
   logic [7:0]  w_win_b;

   // Requester 1 wins when it is alone, or on a tie when requester 0 had the
   // previous grant.
   assign w_any_valid = io_arb.req0_valid | io_arb.req1_valid;
   assign w_grant_id  = io_arb.req1_valid & (~io_arb.req0_valid | ~r_last_grant);

   // The accept pulse must coincide with the cycle the winner's valid is
   // seen, so ready is decoded from the registered state rather than
   // registered itself. Gating with the reset input keeps it low while
   // reset is held, like every other output.
   assign w_accept = (r_state == S_IDLE) & w_any_valid & ~i_reset_a;

   assign io_arb.req0_ready = w_accept & ~w_grant_id;
   assign io_arb.req1_ready = w_accept &  w_grant_id;

   assign w_win_a = w_grant_id ? io_arb.req1_a : io_arb.req0_a;
   assign w_win_b = w_grant_id ? io_arb.req1_b : io_arb.req0_b;

   assign io_arb.rsp_valid   = r_rsp_valid;
   assign io_arb.rsp_id      = r_rsp_id;
   assign io_arb.rsp_product = r_rsp_product;
   assign io_arb.mult_start  = r_mult_start;
   assign io_arb.mult_dataa  = r_dataa;
   assign io_arb.mult_datab  = r_datab;

`ifdef MULT_ARB_TIMEOUT_EN
   localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

   logic [3:0] r_cnt;
   logic       r_rsp_err;

   assign io_arb.rsp_err = r_rsp_err;
`else
   assign io_arb.rsp_err = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_reset_a) begin
      if (i_reset_a) begin
         r_state       <= S_IDLE;
         r_last_grant  <= 1'b1;
         r_rsp_valid   <= 1'b0;
         r_rsp_id      <= 1'b0;
         r_rsp_product <= 16'h0000;
         r_mult_start  <= 1'b0;
         r_dataa       <= 8'h00;
         r_datab       <= 8'h00;
`ifdef MULT_ARB_TIMEOUT_EN
         r_cnt         <= 4'h0;
         r_rsp_err     <= 1'b0;
`endif
      end else begin
         // Start is only ever raised on the IDLE->START transition, so it
         // is a single-cycle pulse by construction.
         r_mult_start <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_dataa      <= w_win_a;
                  r_datab      <= w_win_b;
                  r_rsp_id     <= w_grant_id;
                  r_mult_start <= 1'b1;
                  r_state      <= S_START;
               end
            end

            S_START: begin
`ifdef MULT_ARB_TIMEOUT_EN
               r_cnt   <= 4'h0;
`endif
               r_state <= S_BUSY;
            end

            S_BUSY: begin
               // Done is checked first so that it wins over a coinciding
               // timeout.
               if (io_arb.mult_done) begin
                  r_rsp_product <= io_arb.mult_product;
                  r_rsp_valid   <= 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
                  r_rsp_err     <= 1'b0;
`endif
                  r_state       <= S_RESP;
               end
`ifdef MULT_ARB_TIMEOUT_EN
               else if (r_cnt == TMO_LAST) begin
                  r_rsp_product <= 16'h0000;
                  r_rsp_err     <= 1'b1;
                  r_rsp_valid   <= 1'b1;
                  r_state       <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 4'h1;
               end
`endif
            end

            S_RESP: begin
               if (io_arb.rsp_ready) begin
                  r_rsp_valid  <= 1'b0;
                  r_last_grant <= r_rsp_id;
                  r_state      <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - self-checking bench for mult_arbiter with a transaction-level reference model
module tb_mult_arbiter;
   localparam int TMO = 12;

   logic clk = 1'b0;
   logic reset_a;

   always #5 clk = ~clk;

   mult_arbiter_if bus ();

   mult_arbiter #(.TIMEOUT(TMO)) dut (
      .i_clk     (clk),
      .i_reset_a (reset_a),
      .io_arb    (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // requester operand queues, {a, b}
   logic [15:0] rq0[$];
   logic [15:0] rq1[$];

   // reference model of the outstanding job
   logic        m_busy, m_rsp, m_last, m_id, m_err;
   logic [7:0]  m_a, m_b;
   logic [15:0] m_prod;
   int          acc_cyc, hs_cyc, rsp_first_cyc;
   int          grants[$];
   logic        log_id[$];
   logic [15:0] log_prod[$];
   logic        log_err[$];

   // stimulus knobs and multiplier plant
   logic        rand_ready, fixed_ready;
   int          mult_lat, mult_cnt;
   logic [15:0] mult_res;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_req0_ready"}, 32'(bus.req0_ready), 0);
      chk({tag, "_req1_ready"}, 32'(bus.req1_ready), 0);
      chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
      chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 0);
      chk({tag, "_rsp_product"}, 32'(bus.rsp_product), 0);
      chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 0);
      chk({tag, "_mult_start"}, 32'(bus.mult_start), 0);
      chk({tag, "_mult_dataa"}, 32'(bus.mult_dataa), 0);
      chk({tag, "_mult_datab"}, 32'(bus.mult_datab), 0);
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_rsp = 1'b0; m_last = 1'b1; m_id = 1'b0; m_err = 1'b0;
      m_a = 8'h00; m_b = 8'h00; m_prod = 16'h0000;
      acc_cyc = -100; hs_cyc = -100; rsp_first_cyc = -1;
      mult_cnt = 0; mult_res = 16'h0000;
   endtask

   task automatic clear_logs();
      grants.delete(); log_id.delete(); log_prod.delete(); log_err.delete();
   endtask

   task automatic monitor();
      logic exp_acc, exp_win, rsp_next;
      exp_acc = !m_busy && (bus.req0_valid || bus.req1_valid);
      exp_win = bus.req1_valid && (!bus.req0_valid || (m_last == 1'b0));
      chk("req0_ready", 32'(bus.req0_ready), 32'(exp_acc && !exp_win));
      chk("req1_ready", 32'(bus.req1_ready), 32'(exp_acc && exp_win));
      chk("mult_start", 32'(bus.mult_start), 32'(m_busy && (cyc == acc_cyc + 1)));
      if (m_busy) begin
         chk("mult_dataa_hold", 32'(bus.mult_dataa), 32'(m_a));
         chk("mult_datab_hold", 32'(bus.mult_datab), 32'(m_b));
         chk("rsp_id_hold", 32'(bus.rsp_id), 32'(m_id));
      end
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp));
      if (m_rsp) begin
         chk("rsp_product", 32'(bus.rsp_product), 32'(m_prod));
         chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
      end
      if (m_busy && bus.rsp_valid && rsp_first_cyc < 0) rsp_first_cyc = cyc;

      rsp_next = m_rsp;
      if (m_busy && !m_rsp && cyc >= acc_cyc + 2) begin
         if (bus.mult_done) begin
            rsp_next = 1'b1;
            m_prod   = {8'h00, m_a} * {8'h00, m_b};
            m_err    = 1'b0;
         end
`ifdef MULT_ARB_TIMEOUT_EN
         else if (cyc == acc_cyc + 1 + TMO) begin
            rsp_next = 1'b1;
            m_prod   = 16'h0000;
            m_err    = 1'b1;
         end
`endif
      end

      if (bus.rsp_valid && bus.rsp_ready) begin
         log_id.push_back(bus.rsp_id);
         log_prod.push_back(bus.rsp_product);
         log_err.push_back(bus.rsp_err);
      end
      if (m_rsp && bus.rsp_ready) begin
         m_last   = m_id;
         m_busy   = 1'b0;
         rsp_next = 1'b0;
         hs_cyc   = cyc;
      end

      if (exp_acc) begin
         m_busy  = 1'b1;
         acc_cyc = cyc;
         m_id    = exp_win;
         rsp_first_cyc = -1;
         if (exp_win) begin
            m_a = rq1[0][15:8]; m_b = rq1[0][7:0]; void'(rq1.pop_front());
         end else begin
            m_a = rq0[0][15:8]; m_b = rq0[0][7:0]; void'(rq0.pop_front());
         end
         grants.push_back(int'(exp_win));
      end
      m_rsp = rsp_next;

      if (bus.mult_start) begin
         mult_cnt = mult_lat;
         mult_res = {8'h00, bus.mult_dataa} * {8'h00, bus.mult_datab};
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      cyc++;
      bus.mult_done    = 1'b0;
      bus.mult_product = 16'($urandom);
      if (mult_cnt > 0) begin
         mult_cnt--;
         if (mult_cnt == 0) begin
            bus.mult_done    = 1'b1;
            bus.mult_product = mult_res;
         end
      end
      bus.req0_valid = (rq0.size() != 0);
      bus.req1_valid = (rq1.size() != 0);
      if (rq0.size() != 0) begin bus.req0_a = rq0[0][15:8]; bus.req0_b = rq0[0][7:0]; end
      else begin bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom); end
      if (rq1.size() != 0) begin bus.req1_a = rq1[0][15:8]; bus.req1_b = rq1[0][7:0]; end
      else begin bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom); end
      bus.rsp_ready = rand_ready ? 1'($urandom) : fixed_ready;
      #1;
      monitor();
   endtask

   task automatic run_until_idle(input string tag, input int max);
      int n;
      n = 0;
      do begin
         cycle();
         n++;
      end while ((m_busy || rq0.size() != 0 || rq1.size() != 0) && n < max);
      chk({tag, "_bound"}, 32'(n < max), 1);
   endtask

   initial begin
      int n, h;
      reset_a = 1'b1;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      bus.req0_a = 8'hAA; bus.req0_b = 8'h55; bus.req1_a = 8'h11; bus.req1_b = 8'h22;
      bus.rsp_ready = 1'b1; bus.mult_done = 1'b1; bus.mult_product = 16'hBEEF;
      rand_ready = 1'b0; fixed_ready = 1'b1; mult_lat = 5;
      model_reset();
      clear_logs();
      #12;
      chk_reset_outs("reset");
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.mult_done = 1'b0;
      @(negedge clk);
      reset_a = 1'b0;

      // tie after reset: requester 0 first
      rq0.push_back({8'd3, 8'd4});
      rq1.push_back({8'd255, 8'd255});
      run_until_idle("tie", 200);
      chk("tie_n_rsp", 32'(log_id.size()), 2);
      if (log_id.size() == 2) begin
         chk("tie_id0", 32'(log_id[0]), 0);
         chk("tie_prod0", 32'(log_prod[0]), 12);
         chk("tie_id1", 32'(log_id[1]), 1);
         chk("tie_prod1", 32'(log_prod[1]), 32'hFE01);
      end

      // fairness: both held valid for four jobs
      clear_logs();
      for (int i = 0; i < 2; i++) begin
         rq0.push_back(16'($urandom));
         rq1.push_back(16'($urandom));
      end
      run_until_idle("fair", 400);
      chk("fair_n", 32'(grants.size()), 4);
      if (grants.size() == 4) begin
         chk("fair_g0", 32'(grants[0]), 0);
         chk("fair_g1", 32'(grants[1]), 1);
         chk("fair_g2", 32'(grants[2]), 0);
         chk("fair_g3", 32'(grants[3]), 1);
      end

      // single request with latency
      clear_logs();
      rq0.push_back({8'd5, 8'd7});
      run_until_idle("single", 100);
      chk("single_latency", 32'(rsp_first_cyc - acc_cyc), 7);
      chk("single_n", 32'(log_prod.size()), 1);
      if (log_prod.size() == 1) begin
         chk("single_prod", 32'(log_prod[0]), 35);
         chk("single_id", 32'(log_id[0]), 0);
         chk("single_err", 32'(log_err[0]), 0);
      end

      // backpressure: response held 10 cycles
      clear_logs();
      fixed_ready = 1'b0;
      rq0.push_back(16'($urandom));
      rq1.push_back(16'($urandom));
      n = 0;
      while (!m_rsp && n < 50) begin cycle(); n++; end
      chk("bp_reach_resp", 32'(n < 50), 1);
      repeat (10) cycle();
      chk("bp_no_accept", 32'(grants.size()), 1);
      fixed_ready = 1'b1;
      cycle();
      h = hs_cyc;
      chk("bp_hs_now", 32'(h == cyc), 1);
      cycle();
      chk("bp_next_grant", 32'(acc_cyc - h), 1);
      run_until_idle("bp", 100);
      chk("bp_n", 32'(log_id.size()), 2);

      // randomized traffic
      clear_logs();
      rand_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0 && rq0.size() < 3) rq0.push_back(16'($urandom));
         if ($urandom_range(0, 5) == 0 && rq1.size() < 3) rq1.push_back(16'($urandom));
         mult_lat = $urandom_range(1, 8);
         cycle();
      end
      rand_ready = 1'b0;
      fixed_ready = 1'b1;
      mult_lat = 5;
      run_until_idle("rand", 500);
      chk("rand_some_jobs", 32'(log_id.size() > 10), 1);

`ifdef MULT_ARB_TIMEOUT_EN
      // watchdog abort, then a normal job
      clear_logs();
      mult_lat = 0;
      rq0.push_back(16'($urandom));
      run_until_idle("tmo", 100);
      chk("tmo_latency", 32'(rsp_first_cyc - acc_cyc), 32'(TMO + 2));
      chk("tmo_n", 32'(log_err.size()), 1);
      if (log_err.size() == 1) begin
         chk("tmo_err", 32'(log_err[0]), 1);
         chk("tmo_prod", 32'(log_prod[0]), 0);
      end
      mult_lat = 5;
      rq1.push_back({8'd9, 8'd9});
      run_until_idle("tmo_next", 100);
      chk("tmo_next_n", 32'(log_err.size()), 2);
      if (log_err.size() == 2) begin
         chk("tmo_next_err", 32'(log_err[1]), 0);
         chk("tmo_next_prod", 32'(log_prod[1]), 81);
      end
`endif

      // reset during BUSY
      clear_logs();
      mult_lat = 5;
      rq0.push_back(16'($urandom));
      n = 0;
      while (!m_busy && n < 20) begin cycle(); n++; end
      chk("rstb_accept", 32'(m_busy), 1);
      repeat (3) cycle();
      reset_a = 1'b1;
      #1;
      chk_reset_outs("rst_busy");
      model_reset();
      rq0.delete();
      rq1.delete();
      @(posedge clk);
      #1;
      chk_reset_outs("rst_hold");
      @(negedge clk);
      reset_a = 1'b0;
      rq0.push_back(16'($urandom));
      rq1.push_back(16'($urandom));
      run_until_idle("rst_after", 200);
      chk("rst_after_n", 32'(log_id.size()), 2);
      if (log_id.size() == 2) begin
         chk("rst_after_first", 32'(log_id[0]), 0);
         chk("rst_after_second", 32'(log_id[1]), 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
